iodelay_train_tx: RTL

Transmit-side companion to the receive IODELAY calibration logic. In idle it drives a forwarded clock pattern on a differential pair. On a calibration request it steps its own output-delay tap setting across the full range, and sends a preamble plus a known training burst at each tap so the far-end receiver can lock and score every setting. It sits in the I/O ring next to the PLL-forwarded clock output and runs in the `clk_in` domain.

---
 rtl/iodelay_train_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/iodelay_train_tx.sv
// iodelay_train_tx: transmit-side IODELAY training sequencer.
// Idle drives a forwarded-clock toggle on dout_p/dout_n. On cal_start it sends
// a preamble, then for every output-delay tap it loads the tap, holds the line
// low while the delay settles, and sends a fixed training burst.
// Build option: define IODELAY_TX_PRBS_EN to send PRBS7 (x^7+x^6+1, seeded
// 7'h7F per burst) instead of the repeating 8'hCA word.
// Every output is a register loaded from the decode of the next state, so the
// outputs always describe the state the FSM is currently in.
module iodelay_train_tx #(
    parameter int TAP_W   = 5,
    parameter int NTAPS   = 32,
    parameter int PRE_LEN = 16,
    parameter int SETTLE  = 4,
    parameter int BURST   = 64
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             cal_start,
    output logic [TAP_W-1:0] tap_out,
    output logic             tap_ld,
    output logic             dout_p,
    output logic             dout_n,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_BURST  = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam int                CNT_W       = 16;
    localparam logic [CNT_W-1:0]  PRE_LAST    = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  BURST_LAST  = CNT_W'(BURST - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(NTAPS - 1);
    localparam logic              NO_SETTLE   = (SETTLE == 0) ? 1'b1 : 1'b0;

`ifdef IODELAY_TX_PRBS_EN
    // PRBS7 generator: state is the LFSR, the emitted bit is its MSB.
    localparam int               PAT_W    = 7;
    localparam logic [PAT_W-1:0] PAT_SEED = 7'h7F;

    function automatic logic pat_bit(input logic [PAT_W-1:0] s);
        return s[6];
    endfunction

    function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction
`else
    // Fixed word generator: state is the bit index, walked MSB first.
    localparam int               PAT_W    = 3;
    localparam logic [PAT_W-1:0] PAT_SEED = 3'd7;
    localparam logic [7:0]       PAT_WORD = 8'hCA;

    function automatic logic pat_bit(input logic [PAT_W-1:0] s);
        return PAT_WORD[s];
    endfunction

    function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] s);
        return s - 3'd1;
    endfunction
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [TAP_W-1:0]   tap_out_q, tap_out_d;
    logic               tap_ld_q, tap_ld_d;
    logic               dout_p_q, dout_p_d;
    logic               dout_n_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state/counter logic, then output decode of the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tap_cnt_d = tap_cnt_q;
        pat_d     = PAT_SEED;
        tap_out_d = tap_out_q;
        tap_ld_d  = 1'b0;
        dout_p_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cal_start) begin
                    state_d   = S_PRE;
                    cnt_d     = {CNT_W{1'b0}};
                    tap_cnt_d = {TAP_W{1'b0}};
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_LOAD: begin
                cnt_d = {CNT_W{1'b0}};
                if (NO_SETTLE) begin
                    state_d = S_BURST;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_BURST;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_BURST: begin
                if (cnt_q == BURST_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (tap_cnt_q == TAP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_LOAD;
                        tap_cnt_d = tap_cnt_q + TAP_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The generator sits at its seed outside BURST, so each burst
        // (including one entered straight from LOAD) restarts the sequence.
        case (state_d)
            S_IDLE: begin
                dout_p_d = ~dout_p_q;
            end
            S_PRE: begin
                dout_p_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_LOAD: begin
                tap_out_d = tap_cnt_d;
                tap_ld_d  = 1'b1;
                busy_d    = 1'b1;
            end
            S_SETTLE: begin
                busy_d = 1'b1;
            end
            S_BURST: begin
                dout_p_d = pat_bit(pat_q);
                pat_d    = pat_next(pat_q);
                busy_d   = 1'b1;
            end
            S_DONE: begin
                tap_out_d = {TAP_W{1'b0}};
                tap_ld_d  = 1'b1;
                done_d    = 1'b1;
            end
            default: begin
                dout_p_d = 1'b0;
            end
        endcase
    end

    // State, counters, generator and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            tap_cnt_q <= {TAP_W{1'b0}};
            pat_q     <= PAT_SEED;
            tap_out_q <= {TAP_W{1'b0}};
            tap_ld_q  <= 1'b0;
            dout_p_q  <= 1'b0;
            dout_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tap_cnt_q <= tap_cnt_d;
            pat_q     <= pat_d;
            tap_out_q <= tap_out_d;
            tap_ld_q  <= tap_ld_d;
            dout_p_q  <= dout_p_d;
            dout_n_q  <= ~dout_p_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tap_out = tap_out_q;
    assign tap_ld  = tap_ld_q;
    assign dout_p  = dout_p_q;
    assign dout_n  = dout_n_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
